// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: single-cycle ALU/branch ops plus iterative MULTU/DIVU with HI/LO,
// one result slot with valid/ready handshake, flush and branch redirect.
module exe_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [SH_W-1:0]   in_shamt,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_target,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              redirect,
    output logic [31:0]       redirect_addr,
    input  logic              flush_in,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;
    state_e state_q, state_d;
    logic [DATA_W-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d, opd_q, opd_d, alu;
    logic [2*DATA_W-1:0] p_q, p_d, step;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [31:0]         raddr_q, raddr_d, a32;
    logic [SH_W-1:0]     cnt_q, cnt_d;
    logic                valid_q, valid_d, redir_q, redir_d, div_q, div_d;
    logic                accept, long_op, bubble, taken;
    logic [DATA_W:0]     mul_sum, div_sh, div_trial;

    assign in_ready = state_q == IDLE || (state_q == HOLD && out_ready);
    assign accept   = in_valid && in_ready && !flush_in;
    assign long_op  = in_op == 4'd8 || in_op == 4'd9;
    assign bubble   = in_pc == '0;
    assign a32      = 32'(in_a);
    assign taken    = (in_op == 4'd12 && in_a == in_b) || (in_op == 4'd13 && in_a != in_b) || in_op == 4'd14;

    always_comb begin
        alu = '0;
        case (in_op)
            4'd0:  alu = in_a + in_b;
            4'd1:  alu = in_a - in_b;
            4'd2:  alu = in_a & in_b;
            4'd3:  alu = in_a | in_b;
            4'd4:  alu = in_a ^ in_b;
            4'd5:  alu = {{(DATA_W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'd6:  alu = in_a << in_shamt;
            4'd7:  alu = in_a >> in_shamt;
            4'd10: alu = hi_q;
            4'd11: alu = lo_q;
            default: alu = '0;
        endcase
    end

    // p_q holds {partial product, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU
    assign mul_sum   = {1'b0, p_q[2*DATA_W-1:DATA_W]} + {1'b0, opd_q & {DATA_W{p_q[0]}}};
    assign div_sh    = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
    assign div_trial = div_sh - {1'b0, opd_q};
    assign step = !div_q       ? {mul_sum, p_q[DATA_W-1:1]} :
                  div_trial[DATA_W] ? {div_sh[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0} :
                                 {div_trial[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        redir_d = 1'b0;
        raddr_d = '0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_d     = p_q;
        opd_d   = opd_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
        if (state_q == BUSY) begin
            p_d   = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = HOLD;
                valid_d = 1'b1;
                res_d   = step[DATA_W-1:0];
                hi_d    = step[2*DATA_W-1:DATA_W];
                lo_d    = step[DATA_W-1:0];
            end
        end
        if (accept && !bubble) begin
            tag_d = in_tag;
            if (long_op) begin
                state_d = BUSY;
                valid_d = 1'b0;
                div_d   = in_op[0];
                opd_d   = in_op[0] ? in_b : in_a;
                p_d     = {{DATA_W{1'b0}}, in_op[0] ? in_a : in_b};
                cnt_d   = SH_W'(DATA_W - 1);
            end else begin
                state_d = HOLD;
                valid_d = 1'b1;
                res_d   = alu;
                redir_d = taken;
                raddr_d = !taken ? '0 : in_op == 4'd14 ? a32 : in_target;
            end
        end
        if (flush_in) begin
            state_d = IDLE;
            valid_d = 1'b0;
            redir_d = 1'b0;
            raddr_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            res_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            redir_q <= 1'b0;
            raddr_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
            opd_q   <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            redir_q <= redir_d;
            raddr_q <= raddr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
            opd_q   <= opd_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_result    = res_q;
    assign out_tag       = tag_q;
    assign redirect      = redir_q;
    assign redirect_addr = raddr_q;
    assign hi            = hi_q;
    assign lo            = lo_q;
endmodule
